saradc_sw_bbm_seq: RTL and testbench
====================================

# saradc_sw_bbm_seq

Break-before-make sequencer for banks of SAR ADC analog pass-gate switches. It drives the complementary S/SB control pairs of N_CH channels, each with N_SEL selectable switch targets (e.g. CDAC bottom plate to VCM/VREFP/VREFN). A new switch configuration is accepted over a valid/ready handshake. Every changed channel is opened fully for a programmable dead time before its new target closes, so no two targets of a channel ever conduct at once.

## Interface

Parameters:
- N_CH, 8: number of switch channels.
- N_SEL, 3: switch targets per channel.
- DEAD, 2: all-open dead time in CLK cycles. Legal range is DEAD ≥ 1.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- REQ_VALID  in  1  new configuration offered.
- REQ_READY  out  1  sequencer can accept a configuration.
- REQ_SEL  in  N_CH*N_SEL  per-channel target vector. Channel c uses bits [c*N_SEL +: N_SEL]. One-hot closes that target; zero means all open.
- S  out  N_CH*N_SEL  switch enables, registered, same bit mapping as REQ_SEL.
- SB  out  N_CH*N_SEL  registered exact complement of S.
- BUSY  out  1  dead-time sequence in progress.
- DONE  out  1  one-cycle pulse: new configuration applied.
- ERR  out  1  last accepted request had an illegal channel.

Clocking and reset:
- Single clock domain (CLK).
- Synchronous active-high reset (RST).

## Operation

States: IDLE and OPEN.

Reset (RST=1 at an edge):
- S=0, SB=all ones, state IDLE, count cleared.
- DONE=0, ERR=0, BUSY=0.
- REQ_READY=0 while RST is high.
- Reset overrides any sequence in progress. There is no partial make.

Handshake:
- REQ_READY = (state==IDLE) && !RST.
- A request is accepted at an edge where REQ_VALID && REQ_READY. REQ_SEL is latched at that edge.

Legalisation (at accept):
- A channel with more than one bit set in REQ_SEL is illegal.
- An illegal channel's target is forced to zero (all open).
- ERR is set to the OR of illegal channels and holds until the next accept or reset.

Change detection:
- Channel c has changed if its legalised target differs from its current S slice.

Accept with at least one changed channel (edge E0):
- Changed channels get S slice := 0. Unchanged channels keep S untouched, with no glitch.
- State goes to OPEN, count := DEAD-1, BUSY=1.

In OPEN:
- If count≠0: count decrements.
- If count==0: all changed channels load their legalised targets, DONE pulses for one cycle, state goes to IDLE, BUSY=0.

Accept with no changed channel:
- S is unchanged and state stays IDLE.
- DONE pulses at E0. ERR is still updated.

A channel going from closed to zero, or from zero to closed, counts as changed and takes the full dead time.

SB is always the bitwise inverse of S, updated at the same edge. No cycle may show S and SB equal.

Counter width is clog2(DEAD+1).

## Timing

- Break: changed channels are all-open starting at E0.
- Dead time: they remain all-open for exactly DEAD cycles.
- Make: new targets appear at edge E0+DEAD.
- At E0+DEAD, DONE=1 for that single cycle and REQ_READY returns to 1. The earliest next accept is edge E0+DEAD+1.
- BUSY=1 from E0 through the cycle before E0+DEAD.
- No-change request: DONE is asserted at E0, and REQ_READY stays 1 throughout.
- Within one channel, two targets are never closed in the same cycle, including across back-to-back requests.
- REQ_VALID held high while REQ_READY=0 has no effect. The request is taken at the first edge where REQ_READY=1.

## Test plan

All scenarios use N_CH=2, N_SEL=3, DEAD=2.

1. Reset, then observe: S=0, SB=6'b111111, REQ_READY=1 one cycle after RST drops, DONE=0, ERR=0.
2. Request REQ_SEL=6'b010_001 from reset. Required response:
   - S stays 0 at E0 and E0+1.
   - S=6'b010_001 at E0+2, with DONE pulsing there.
   - BUSY high for 2 cycles.
3. From 6'b010_001, request 6'b010_100. Required response:
   - Channel 1 holds 3'b010 throughout.
   - Channel 0 is 3'b000 at E0 and E0+1, and 3'b100 at E0+2.
   - Channel 0 never shows two bits set.
4. Request REQ_SEL equal to the current S: DONE pulses at E0, S is unchanged, BUSY stays 0.
5. Request 6'b011_001 (channel 1 illegal). Required response:
   - ERR=1.
   - Channel 1 is forced to 3'b000 and channel 0 = 3'b001.
   - A following legal request clears ERR.
6. Assert RST at E0+1 of a pending sequence. At the next edge: S=0, BUSY=0, no DONE pulse, and REQ_READY=1 after RST deasserts.

Source files
------------

// File: rtl/saradc_sw_bbm_seq.sv
// Break-before-make sequencer for SAR ADC pass-gate switch banks.
// Changed channels open fully for DEAD cycles before their new target closes.
module saradc_sw_bbm_seq #(
  parameter int unsigned N_CH  = 8,
  parameter int unsigned N_SEL = 3,
  parameter int unsigned DEAD  = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [N_CH*N_SEL-1:0] req_sel_i,
  output logic [N_CH*N_SEL-1:0] s_o,
  output logic [N_CH*N_SEL-1:0] sb_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int unsigned W  = N_CH * N_SEL;
  localparam int unsigned CW = $clog2(DEAD + 1);

  typedef enum logic {
    ST_IDLE,
    ST_OPEN
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    s_q, s_d;
  logic [W-1:0]    sb_q, sb_d;
  logic [W-1:0]    tgt_q, tgt_d;
  logic [W-1:0]    chg_q, chg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic [W-1:0]    legal_c;
  logic [W-1:0]    chg_c;
  logic            illegal_c;
  logic            accept_c;

  // Legalise the offered vector and compare each channel against the live S slice
  always_comb begin
    logic [N_SEL-1:0] sl;
    logic             ill;
    legal_c   = '0;
    chg_c     = '0;
    illegal_c = 1'b0;
    sl        = '0;
    ill       = 1'b0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      sl  = req_sel_i[c*N_SEL +: N_SEL];
      ill = |(sl & (sl - N_SEL'(1)));
      if (ill) begin
        sl = '0;
      end
      illegal_c                 = illegal_c | ill;
      legal_c[c*N_SEL +: N_SEL] = sl;
      chg_c[c*N_SEL +: N_SEL]   = {N_SEL{sl != s_q[c*N_SEL +: N_SEL]}};
    end
  end

  assign req_ready_o = (state_q == ST_IDLE) && !rst_i;
  assign accept_c    = req_valid_i && req_ready_o;

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    tgt_d   = tgt_q;
    chg_d   = chg_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          err_d = illegal_c;
          if (|chg_c) begin
            s_d     = s_q & ~chg_c;
            tgt_d   = legal_c;
            chg_d   = chg_c;
            cnt_d   = CW'(DEAD - 1);
            busy_d  = 1'b1;
            state_d = ST_OPEN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_OPEN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          s_d     = (s_q & ~chg_q) | (tgt_q & chg_q);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    sb_d = ~s_d;
  end

  // State registers; reset opens every switch at once
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      sb_q    <= '1;
      tgt_q   <= '0;
      chg_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      sb_q    <= sb_d;
      tgt_q   <= tgt_d;
      chg_q   <= chg_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign s_o    = s_q;
  assign sb_o   = sb_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_saradc_sw_bbm_seq.sv
// Directed bench for saradc_sw_bbm_seq with N_CH=2, N_SEL=3, DEAD=2.
module tb_saradc_sw_bbm_seq;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [5:0] req_sel;
  logic [5:0] s;
  logic [5:0] sb;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  saradc_sw_bbm_seq #(.N_CH(2), .N_SEL(3), .DEAD(2)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_sel_i   (req_sel),
    .s_o         (s),
    .sb_o        (sb),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sample S, SB, BUSY, DONE and READY one step after an edge
  task automatic expect_state(input string name, input logic [5:0] es, input logic eb,
                              input logic ed, input logic er);
    checks++;
    if (s !== es) begin
      errors++;
      $display("FAIL %s s: got %b expected %b", name, s, es);
    end
    checks++;
    if (sb !== ~es) begin
      errors++;
      $display("FAIL %s sb: got %b expected %b", name, sb, ~es);
    end
    checks++;
    if (busy !== eb) begin
      errors++;
      $display("FAIL %s busy: got %b expected %b", name, busy, eb);
    end
    checks++;
    if (done !== ed) begin
      errors++;
      $display("FAIL %s done: got %b expected %b", name, done, ed);
    end
    checks++;
    if (req_ready !== er) begin
      errors++;
      $display("FAIL %s ready: got %b expected %b", name, req_ready, er);
    end
  endtask

  task automatic expect_err(input string name, input logic ee);
    checks++;
    if (err !== ee) begin
      errors++;
      $display("FAIL %s err: got %b expected %b", name, err, ee);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_sel = '0;
    tick(); tick();
    expect_state("reset_held", 6'b000000, 1'b0, 1'b0, 1'b0);
    expect_err("reset_held", 1'b0);
    rst = 1'b0;
    tick();
    expect_state("reset_released", 6'b000000, 1'b0, 1'b0, 1'b1);
    expect_err("reset_released", 1'b0);
  endtask

  task automatic test_first_config();
    req_valid = 1'b1; req_sel = 6'b010_001;
    tick();
    req_valid = 1'b0;
    expect_state("first_e0", 6'b000000, 1'b1, 1'b0, 1'b0);
    tick();
    expect_state("first_e1", 6'b000000, 1'b1, 1'b0, 1'b0);
    tick();
    expect_state("first_e2", 6'b010_001, 1'b0, 1'b1, 1'b1);
    tick();
    expect_state("first_e3", 6'b010_001, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_partial_change();
    req_valid = 1'b1; req_sel = 6'b010_100;
    tick();
    req_valid = 1'b0;
    expect_state("partial_e0", 6'b010_000, 1'b1, 1'b0, 1'b0);
    tick();
    expect_state("partial_e1", 6'b010_000, 1'b1, 1'b0, 1'b0);
    tick();
    expect_state("partial_e2", 6'b010_100, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_no_change();
    req_valid = 1'b1; req_sel = 6'b010_100;
    tick();
    req_valid = 1'b0;
    expect_state("nochange_e0", 6'b010_100, 1'b0, 1'b1, 1'b1);
    tick();
    expect_state("nochange_e1", 6'b010_100, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_illegal();
    req_valid = 1'b1; req_sel = 6'b011_001;
    tick();
    req_valid = 1'b0;
    expect_state("illegal_e0", 6'b000_000, 1'b1, 1'b0, 1'b0);
    expect_err("illegal_e0", 1'b1);
    tick(); tick();
    expect_state("illegal_e2", 6'b000_001, 1'b0, 1'b1, 1'b1);
    expect_err("illegal_e2", 1'b1);
    req_valid = 1'b1; req_sel = 6'b001_001;
    tick();
    req_valid = 1'b0;
    expect_state("legal_after_e0", 6'b000_001, 1'b1, 1'b0, 1'b0);
    expect_err("legal_after_e0", 1'b0);
    tick(); tick();
    expect_state("legal_after_e2", 6'b001_001, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1; req_sel = 6'b010_001;
    tick();
    expect_state("b2b_e0", 6'b000_001, 1'b1, 1'b0, 1'b0);
    req_sel = 6'b100_001;
    tick();
    expect_state("b2b_e1", 6'b000_001, 1'b1, 1'b0, 1'b0);
    tick();
    expect_state("b2b_e2", 6'b010_001, 1'b0, 1'b1, 1'b1);
    tick();
    req_valid = 1'b0;
    expect_state("b2b_e3", 6'b000_001, 1'b1, 1'b0, 1'b0);
    tick(); tick();
    expect_state("b2b_e5", 6'b100_001, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_sel = 6'b001_010;
    tick();
    req_valid = 1'b0;
    expect_state("abort_e0", 6'b000_000, 1'b1, 1'b0, 1'b0);
    tick();
    expect_state("abort_e1", 6'b000_000, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    expect_state("abort_rst", 6'b000_000, 1'b0, 1'b0, 1'b0);
    expect_err("abort_rst", 1'b0);
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_ready: got %b expected 1", req_ready);
    end
    tick();
    expect_state("abort_after", 6'b000_000, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_first_config();
    test_partial_change();
    test_no_change();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
